decrypt_unit: RTL

DECRYPT_UNIT -- requirements
Module: decrypt_unit

---
 rtl/decrypt_config.sv | 22 ++
 rtl/key_scheduler.sv | 45 ++++
 rtl/decrypt_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/decrypt_config.sv
// Shared cipher configuration: bit permutation and key-pointer encodings,
// common to the encryption and decryption sides.
package decrypt_config;

  typedef enum logic [1:0] {
    KP_K1 = 2'd0,
    KP_K2 = 2'd1,
    KP_K3 = 2'd2
  } key_ptr_t;

  // Plaintext bit PERM[i] carries intermediate bit i.
  localparam logic [2:0] PERM [8] = '{3'd3, 3'd6, 3'd0, 3'd5, 3'd7, 3'd1, 3'd4, 3'd2};

  function automatic key_ptr_t next_ptr(input key_ptr_t p);
    case (p)
      KP_K1:   return KP_K2;
      KP_K2:   return KP_K3;
      default: return KP_K1;
    endcase
  endfunction

endpackage

// File: rtl/key_scheduler.sv
// Key-pointer / byte-counter schedule with synchronous message resync.
// active_ptr is the key selection for the byte presented this cycle.
module key_scheduler
  import decrypt_config::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic [2:0] rot_freq,
  input  logic       kresync,
  output key_ptr_t   active_ptr
);

  key_ptr_t   ptr_q, ptr_d, base_ptr;
  logic [2:0] cnt_q, cnt_d, base_cnt;

  always_comb begin
    // Resync acts before the schedule step so a same-cycle byte sees k1.
    base_ptr = kresync ? KP_K1 : ptr_q;
    base_cnt = kresync ? '0 : cnt_q;
    ptr_d    = base_ptr;
    cnt_d    = base_cnt;
    if (en && mode) begin
      if (base_cnt == rot_freq) begin
        cnt_d = '0;
        ptr_d = next_ptr(base_ptr);
      end else begin
        cnt_d = base_cnt + 3'd1;
      end
    end
    active_ptr = mode ? base_ptr : KP_K1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= KP_K1;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decrypt_unit.sv
// Byte decryptor: rotate right, XOR active key, inverse bit permutation.
// Result is registered once (OUT_REG=0) or twice (OUT_REG=1).
module decrypt_unit
  import decrypt_config::*;
#(
  parameter int unsigned OUT_REG = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       en,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  input  logic [7:0] k3,
  input  logic [2:0] rot_freq,
  input  logic       shift_en,
  input  logic [2:0] shift_amt,
  input  logic       mode,
  input  logic       kresync,
  output logic [7:0] dout,
  output logic       v
);

  key_ptr_t   active_ptr;
  logic [7:0] key, rot, xr, pt;
  logic [7:0] s1_data_q, s1_data_d;
  logic       s1_v_q, s1_v_d;

  key_scheduler u_key_scheduler (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .rot_freq   (rot_freq),
    .kresync    (kresync),
    .active_ptr (active_ptr)
  );

  always_comb begin
    case (active_ptr)
      KP_K2:   key = k2;
      KP_K3:   key = k3;
      default: key = k1;
    endcase
    rot = 8'({din, din} >> (shift_en ? shift_amt : 3'd0));
    xr  = rot ^ key;
    pt  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pt[PERM[i]] = xr[i];
    end
    s1_data_d = s1_data_q;
    if (en) begin
      s1_data_d = pt;
    end
    s1_v_d = en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q <= '0;
      s1_v_q    <= 1'b0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_v_q    <= s1_v_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [7:0] s2_data_q, s2_data_d;
      logic       s2_v_q;

      always_comb begin
        s2_data_d = s2_data_q;
        if (s1_v_q) begin
          s2_data_d = s1_data_q;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data_q <= '0;
          s2_v_q    <= 1'b0;
        end else begin
          s2_data_q <= s2_data_d;
          s2_v_q    <= s1_v_q;
        end
      end

      assign dout = s2_data_q;
      assign v    = s2_v_q;
    end else begin : g_no_out_reg
      assign dout = s1_data_q;
      assign v    = s1_v_q;
    end
  endgenerate

endmodule
